// File: rtl/phys_reg_tracker.sv
// Physical-register tracker: circular free list of tags plus per-tag ready bits
// feeding the scheduler. Allocates to rename, sets on writeback, refills on commit.
module phys_reg_tracker #(
   parameter int REGISTER_COUNT = 128,
   parameter int ARCH_COUNT     = 32,
   localparam int TW            = $clog2(REGISTER_COUNT)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   output logic [TW-1:0]             alloc_tag,
   input  logic                      wb_valid,
   input  logic [TW-1:0]             wb_tag,
   input  logic                      free_valid,
   input  logic [TW-1:0]             free_tag,
   output logic [REGISTER_COUNT-1:0] register_valid,
   output logic [TW:0]               free_count,
   output logic                      overflow_err
);

   localparam int          MAX_FREE = REGISTER_COUNT - ARCH_COUNT;
   localparam logic [TW:0] MAX_CNT  = (TW+1)'(MAX_FREE);

   logic [TW-1:0]             storage_q [REGISTER_COUNT];
   logic [TW-1:0]             storage_d [REGISTER_COUNT];
   logic [TW-1:0]             head_q, head_d;
   logic [TW-1:0]             tail_q, tail_d;
   logic [TW:0]               free_count_q, free_count_d;
   logic [REGISTER_COUNT-1:0] register_valid_q, register_valid_d;
   logic                      overflow_err_q, overflow_err_d;

   logic alloc_hs;
   logic free_req;
   logic push;

   // Ready is derived only from registered count, so a same-cycle free never bypasses to alloc.
   assign alloc_ready    = (free_count_q != '0);
   assign alloc_tag      = storage_q[head_q];
   assign register_valid = register_valid_q;
   assign free_count     = free_count_q;
   assign overflow_err   = overflow_err_q;

   assign alloc_hs = alloc_valid & alloc_ready;
   assign free_req = free_valid & (free_tag != '0);
   // A full list can still accept a free when an allocate drains one entry in the same cycle.
   assign push     = free_req & ((free_count_q != MAX_CNT) | alloc_hs);

   always_comb begin
      storage_d        = storage_q;
      head_d           = head_q;
      tail_d           = tail_q;
      free_count_d     = free_count_q;
      register_valid_d = register_valid_q;
      overflow_err_d   = overflow_err_q;

      if (push) begin
         storage_d[tail_q] = free_tag;
         tail_d            = tail_q + 1'b1;
      end
      if (alloc_hs) begin
         head_d = head_q + 1'b1;
      end

      if (push && !alloc_hs) begin
         free_count_d = free_count_q + 1'b1;
      end else if (alloc_hs && !push) begin
         free_count_d = free_count_q - 1'b1;
      end

      if (free_req && !push) begin
         overflow_err_d = 1'b1;
      end

      // Clear is applied after set so an allocate beats a writeback to the same tag.
      if (wb_valid && (wb_tag != '0)) begin
         register_valid_d[wb_tag] = 1'b1;
      end
      if (alloc_hs) begin
         register_valid_d[alloc_tag] = 1'b0;
      end
      register_valid_d[0] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REGISTER_COUNT; i++) begin
            storage_q[i] <= (i < MAX_FREE) ? TW'(i + ARCH_COUNT) : '0;
         end
         head_q           <= '0;
         tail_q           <= TW'(MAX_FREE);
         free_count_q     <= MAX_CNT;
         register_valid_q <= '1;
         overflow_err_q   <= 1'b0;
      end else begin
         storage_q        <= storage_d;
         head_q           <= head_d;
         tail_q           <= tail_d;
         free_count_q     <= free_count_d;
         register_valid_q <= register_valid_d;
         overflow_err_q   <= overflow_err_d;
      end
   end

endmodule

// File: tb/tb_phys_reg_tracker.sv
// Directed bench for phys_reg_tracker with a queue-based free-list scoreboard.
module tb_phys_reg_tracker;

   localparam int RC = 128;
   localparam int AC = 32;
   localparam int TW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          av, wv, fv;
   logic [TW-1:0] wt, ft;
   logic          alloc_ready;
   logic [TW-1:0] alloc_tag;
   logic [RC-1:0] register_valid;
   logic [TW:0]   free_count;
   logic          overflow_err;

   int total = 0;
   int bad   = 0;

   int       q[$];
   logic [RC-1:0] m_rv;
   bit       m_err;

   phys_reg_tracker #(.REGISTER_COUNT(RC), .ARCH_COUNT(AC)) dut (
      .clk           (clk),
      .reset         (reset),
      .alloc_valid   (av),
      .alloc_ready   (alloc_ready),
      .alloc_tag     (alloc_tag),
      .wb_valid      (wv),
      .wb_tag        (wt),
      .free_valid    (fv),
      .free_tag      (ft),
      .register_valid(register_valid),
      .free_count    (free_count),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [RC-1:0] obs, input logic [RC-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_init();
      q.delete();
      for (int i = AC; i < RC; i++) q.push_back(i);
      m_rv  = '1;
      m_err = 1'b0;
   endtask

   task automatic idle();
      av = 1'b0; wv = 1'b0; fv = 1'b0; wt = '0; ft = '0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_rv"},    register_valid, {RC{1'b1}});
      check({pfx, "_ready"}, alloc_ready, 1);
      check({pfx, "_tag"},   alloc_tag, AC);
      check({pfx, "_cnt"},   free_count, RC - AC);
      check({pfx, "_err"},   overflow_err, 0);
   endtask

   // One clock of traffic: scoreboard update from the current inputs, then post-edge compare.
   task automatic cyc();
      bit hs, push;
      int t;
      hs = av && (q.size() != 0);
      check("ready_pre", alloc_ready, (q.size() != 0));
      if (q.size() != 0) check("tag_pre", alloc_tag, q[0]);
      push = fv && (ft != 0) && ((q.size() != RC - AC) || hs);
      if (fv && (ft != 0) && !push) m_err = 1'b1;
      if (wv && (wt != 0)) m_rv[wt] = 1'b1;
      if (hs) begin
         t = q.pop_front();
         m_rv[t] = 1'b0;
      end
      if (push) q.push_back(int'(ft));
      @(posedge clk); #1;
      check("ready", alloc_ready, (q.size() != 0));
      check("count", free_count, q.size());
      check("rv", register_valid, m_rv);
      check("err", overflow_err, m_err);
   endtask

   task automatic sync_reset_seq();
      idle();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_init();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      model_init();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      check_reset_outputs("rst");

      // Three back-to-back allocations.
      check("t32", alloc_tag, 32);
      av = 1'b1; cyc();
      check("t33", alloc_tag, 33);
      check("rv32_clr", register_valid[32], 0);
      cyc();
      check("t34", alloc_tag, 34);
      cyc();
      check("cnt93", free_count, 93);
      check("rv34_clr", register_valid[34], 0);

      // Writeback restores the ready bit one cycle later; tag 0 is ignored.
      idle(); cyc();
      wv = 1'b1; wt = 7'd32; cyc();
      check("rv32_set", register_valid[32], 1);
      wt = 7'd0; cyc();
      check("rv_wb0", register_valid, m_rv);
      idle();

      // Drain the list, then free 5 with alloc asserted: no same-cycle bypass.
      av = 1'b1;
      repeat (93) cyc();
      check("empty_cnt", free_count, 0);
      check("empty_ready", alloc_ready, 0);
      fv = 1'b1; ft = 7'd5; cyc();
      idle();
      check("refill_ready", alloc_ready, 1);
      check("refill_tag", alloc_tag, 5);
      av = 1'b1; cyc();
      idle();

      // Seed ten entries, then alloc/free pairs past the wrap point.
      fv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ft = TW'(40 + i); cyc();
      end
      av = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ft = TW'($urandom_range(1, RC - 1));
         cyc();
      end
      check("pair_cnt", free_count, 10);
      idle();

      // Allocate of tag 40 with a same-cycle writeback to 40: clear wins.
      sync_reset_seq();
      av = 1'b1;
      repeat (8) cyc();
      check("t40", alloc_tag, 40);
      wv = 1'b1; wt = 7'd40; cyc();
      check("rv40_clr", register_valid[40], 0);
      idle();

      // Alloc+free at maximum count is legal; a lone free at maximum overflows.
      sync_reset_seq();
      av = 1'b1; fv = 1'b1; ft = 7'd9; cyc();
      check("max_pair_err", overflow_err, 0);
      check("max_pair_cnt", free_count, 96);
      av = 1'b0; ft = 7'd7; cyc();
      check("ovf_err", overflow_err, 1);
      check("ovf_cnt", free_count, 96);
      ft = 7'd0; cyc();
      check("ovf_sticky", overflow_err, 1);
      idle();

      // Asynchronous reset mid-traffic, away from any clock edge.
      av = 1'b1; wv = 1'b1; wt = 7'd3;
      repeat (5) cyc();
      #3 reset = 1'b0;
      #1 check_reset_outputs("async");
      idle();
      @(posedge clk); #1;
      reset = 1'b1;
      model_init();
      check_reset_outputs("post");
      av = 1'b1; cyc();
      idle(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
